// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU/comparator with single-entry result register and iterative multiplier
// One op in flight: ADD/SUB/AND finish on the accept edge, MUL runs a shift-add engine for WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             overflow,
    output logic             greater,
    output logic             less,
    output logic             is_eq
);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FULL = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_step;
    logic [CW-1:0]      cnt_q;
    logic               ov_q, par_q, gt_q, lt_q, eq_q;
    logic [2:0]         cmp_pend_q;
    logic               accept, mul_done;
    logic [WIDTH-1:0]   sum, diff, alu_y;
    logic               alu_ov, gt_c, lt_c, eq_c;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_FULL) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_done = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        sum    = a + b;
        diff   = a - b;
        alu_y  = a & b;
        alu_ov = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y  = sum;
                alu_ov = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_y  = diff;
                alu_ov = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            default: ;
        endcase
        if (SIGNED_CMP) begin
            gt_c = $signed(a) > $signed(b);
            lt_c = $signed(a) < $signed(b);
        end else begin
            gt_c = a > b;
            lt_c = a < b;
        end
        eq_c = (a == b);
    end

    // A FULL accept retires the old result and loads the new op on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FULL: begin
                if (accept) begin
                    state_d = (op == OP_MUL) ? S_MUL : S_FULL;
                end else if ((state_q == S_FULL) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d = S_FULL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compare flags of a MUL are parked until the product lands, so all outputs update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= '0;
            ov_q       <= 1'b0;
            par_q      <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            cmp_pend_q <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                cmp_pend_q <= {gt_c, lt_c, eq_c};
                acc_q      <= '0;
                mcand_q    <= {{WIDTH{1'b0}}, a};
                mplier_q   <= b;
                cnt_q      <= '0;
            end else begin
                y_q   <= alu_y;
                ov_q  <= alu_ov;
                par_q <= ^alu_y;
                gt_q  <= gt_c;
                lt_q  <= lt_c;
                eq_q  <= eq_c;
            end
        end else if (state_q == S_MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (mul_done) begin
                y_q   <= acc_step[WIDTH-1:0];
                ov_q  <= |acc_step[2*WIDTH-1:WIDTH];
                par_q <= ^acc_step[WIDTH-1:0];
                {gt_q, lt_q, eq_q} <= cmp_pend_q;
            end
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign y         = y_q;
    assign parity    = par_q;
    assign overflow  = ov_q;
    assign greater   = gt_q;
    assign less      = lt_q;
    assign is_eq     = eq_q;
endmodule
